// File: rtl/wb_lsu_master.sv
// Wishbone classic single-access master for the load/store unit.
// Issues one bus cycle per request with lane selects and replicated write data, and returns the extended load data or an error.
module wb_lsu_master #(
    parameter int XLEN           = 32,
    parameter int ADDR_BITS      = 17,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [XLEN-1:0]      req_addr_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [XLEN-1:0]      req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [XLEN-1:0]      rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [XLEN-1:0]      master_dat_o,
    input  logic [XLEN-1:0]      master_dat_i,
    output logic [ADDR_BITS-3:0] adr_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [3:0]           sel_o,
    input  logic                 ack_i,
    input  logic                 err_i
);

    // state | meaning
    // IDLE  | ready for a request; ack_i/err_i ignored
    // BUS   | cycle in flight, waiting for ack_i/err_i or timeout
    // RESP  | one-cycle response strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [1:0]             size_q, size_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic                   uns_q, uns_d;

    logic                   req_ready_d, rsp_valid_d, rsp_err_d;
    logic [XLEN-1:0]        rsp_rdata_d, master_dat_d;
    logic [ADDR_BITS-3:0]   adr_d;
    logic                   cyc_d, stb_d, we_d;
    logic [3:0]             sel_d;

    logic                   req_illegal;
    logic [3:0]             sel_req;
    logic [XLEN-1:0]        dat_req;
    logic [XLEN-1:0]        byte_sh, half_sh, load_ext;
    logic                   unused_addr;

    assign unused_addr = ^req_addr_i[XLEN-1:ADDR_BITS];

    always_comb begin
        req_illegal = (req_size_i == 2'b11)
                    || (req_size_i == 2'b01 && req_addr_i[0])
                    || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
        case (req_size_i)
            2'b00: begin
                sel_req = 4'b0001 << req_addr_i[1:0];
                dat_req = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_req = req_addr_i[1] ? 4'b1100 : 4'b0011;
                dat_req = {2{req_wdata_i[15:0]}};
            end
            default: begin
                sel_req = 4'b1111;
                dat_req = req_wdata_i;
            end
        endcase
    end

    // Lane extraction uses the request fields latched at acceptance.
    always_comb begin
        byte_sh = master_dat_i >> {addr_lo_q, 3'b000};
        half_sh = master_dat_i >> {addr_lo_q[1], 4'b0000};
        case (size_q)
            2'b00:   load_ext = {{(XLEN-8){~uns_q & byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~uns_q & half_sh[15]}}, half_sh[15:0]};
            default: load_ext = master_dat_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        addr_lo_d    = addr_lo_q;
        uns_d        = uns_q;
        req_ready_d  = req_ready_o;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        master_dat_d = master_dat_o;
        adr_d        = adr_o;
        cyc_d        = cyc_o;
        stb_d        = stb_o;
        we_d         = we_o;
        sel_d        = sel_o;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i) begin
                    size_d      = req_size_i;
                    addr_lo_d   = req_addr_i[1:0];
                    uns_d       = req_unsigned_i;
                    req_ready_d = 1'b0;
                    if (req_illegal) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d      = ST_BUS;
                        cnt_d        = '0;
                        cyc_d        = 1'b1;
                        stb_d        = 1'b1;
                        we_d         = req_we_i;
                        adr_d        = req_addr_i[ADDR_BITS-1:2];
                        sel_d        = sel_req;
                        master_dat_d = req_we_i ? dat_req : '0;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (err_i || ack_i || cnt_q == TO_LAST) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = '0;
                    master_dat_d = '0;
                    // err_i wins over ack_i; no ack at all means timeout
                    if (!err_i && ack_i) begin
                        rsp_rdata_d = we_o ? '0 : load_ext;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            addr_lo_q    <= '0;
            uns_q        <= 1'b0;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_rdata_o  <= '0;
            master_dat_o <= '0;
            adr_o        <= '0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            sel_o        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            addr_lo_q    <= addr_lo_d;
            uns_q        <= uns_d;
            req_ready_o  <= req_ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_err_o    <= rsp_err_d;
            rsp_rdata_o  <= rsp_rdata_d;
            master_dat_o <= master_dat_d;
            adr_o        <= adr_d;
            cyc_o        <= cyc_d;
            stb_o        <= stb_d;
            we_o         <= we_d;
            sel_o        <= sel_d;
        end
    end

endmodule
